// File: rtl/adc_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : adc_accumulator
// Summary  : Per-channel sample accumulator for a multiplexed ADC. Builds
//            frames {nsamp, timestamp, ch0..chN-1} and hands them to a
//            valid/ready consumer. Frames that cannot be delivered are dropped
//            and flagged with a sticky overrun bit.
// Options  : define ADC_ACCUMULATOR_DROP_COUNT_EN to add a 16-bit saturating
//            drop_count_o output.
// Revision : 1.0 - initial release
// ============================================================================
module adc_accumulator #(
  parameter int NCHANNELS = 8,
  parameter int DATA_W    = 12,
  parameter int NACC_W    = 12,
  parameter int TS_W      = 52,
  localparam int CH_W     = $clog2(NCHANNELS),
  localparam int ACC_W    = DATA_W + NACC_W,
  localparam int OUT_W    = NACC_W + TS_W + NCHANNELS*ACC_W
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              enable_i,
  input  logic [CH_W-1:0]   channel_i,
  input  logic              data_ready_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [NACC_W-1:0] number_of_samples_i,
  input  logic              out_ready_i,
  output logic [OUT_W-1:0]  accumulated_data_o,
  output logic              data_valid_o,
  output logic              overrun_o
`ifdef ADC_ACCUMULATOR_DROP_COUNT_EN
  ,
  output logic [15:0]       drop_count_o
`endif
);

  logic [NACC_W-1:0]          nsamp_q;
  logic [TS_W-1:0]            frame_cnt_q;
  logic [OUT_W-1:0]           out_q;
  logic                       valid_q;
  logic                       overrun_q;

  logic                       take_d;
  logic [NCHANNELS-1:0]       ch_last_d;
  logic [NCHANNELS*ACC_W-1:0] slots_d;
  logic [OUT_W-1:0]           frame_d;
  logic                       frame_done_d;
  logic                       frame_load_d;
  logic                       frame_drop_d;

  // A strobe is a sample only while enabled and addressed to an existing channel.
  assign take_d = data_ready_i && enable_i &&
                  ({1'b0, channel_i} < (CH_W+1)'(NCHANNELS));

  for (genvar c = 0; c < NCHANNELS; c++) begin : g_ch
    logic [ACC_W-1:0]  ax_q;
    logic [NACC_W-1:0] cx_q;
    logic [ACC_W-1:0]  slot_q;
    logic              hit_d;
    logic [ACC_W-1:0]  sum_d;

    assign hit_d        = take_d && (channel_i == CH_W'(c));
    // First sample of a run restarts the sum instead of adding to stale data.
    assign sum_d        = (cx_q == '0) ? ACC_W'(data_i) : ax_q + ACC_W'(data_i);
    assign ch_last_d[c] = hit_d && (cx_q == nsamp_q);

    // Accumulate samples; the last sample of a run publishes the sum to the slot.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        ax_q   <= '0;
        cx_q   <= '0;
        slot_q <= '0;
      end else if (!enable_i) begin
        cx_q <= '0;
      end else if (hit_d) begin
        ax_q <= sum_d;
        if (ch_last_d[c]) begin
          cx_q   <= '0;
          slot_q <= sum_d;
        end else begin
          cx_q <= cx_q + 1'b1;
        end
      end
    end

    // The last channel closes the frame, so its slot is taken from the live sum.
    if (c == NCHANNELS-1) begin : g_last
      assign slots_d[(NCHANNELS-1-c)*ACC_W +: ACC_W] = sum_d;
    end else begin : g_hold
      assign slots_d[(NCHANNELS-1-c)*ACC_W +: ACC_W] = slot_q;
    end
  end

  assign frame_done_d = ch_last_d[NCHANNELS-1];
  assign frame_load_d = frame_done_d && (!valid_q || out_ready_i);
  assign frame_drop_d = frame_done_d && valid_q && !out_ready_i;
  assign frame_d      = {nsamp_q, frame_cnt_q, slots_d};

  // Frame sequencing, output register and valid/ready handshake.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      nsamp_q     <= number_of_samples_i;
      frame_cnt_q <= '0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (!enable_i || frame_done_d) begin
        nsamp_q <= number_of_samples_i;
      end
      if (frame_done_d) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      if (frame_load_d) begin
        out_q   <= frame_d;
        valid_q <= 1'b1;
      end else if (valid_q && out_ready_i) begin
        valid_q <= 1'b0;
      end
      if (frame_drop_d) begin
        overrun_q <= 1'b1;
      end
    end
  end

`ifdef ADC_ACCUMULATOR_DROP_COUNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of frames lost because the consumer was not ready.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      drop_cnt_q <= '0;
    end else if (frame_drop_d && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign drop_count_o = drop_cnt_q;
`endif

  assign accumulated_data_o = out_q;
  assign data_valid_o       = valid_q;
  assign overrun_o          = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_accumulator
// Summary  : Scoreboard bench for adc_accumulator. Drives an 8-channel and a
//            5-channel instance with identical stimulus; a reference model
//            pushes expected frames into per-instance queues and a monitor
//            pops and compares them whenever a frame is handed over.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_accumulator;
  localparam int DATA_W = 12;
  localparam int NACC_W = 12;
  localparam int TS_W   = 52;
  localparam int ACC_W  = DATA_W + NACC_W;
  localparam int CH_W   = 3;
  localparam int OUT_W8 = NACC_W + TS_W + 8*ACC_W;
  localparam int OUT_W5 = NACC_W + TS_W + 5*ACC_W;

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic [CH_W-1:0]   channel;
  logic              data_ready;
  logic [DATA_W-1:0] data;
  logic [NACC_W-1:0] nos;
  logic              out_ready;
  logic [OUT_W8-1:0] acc8;
  logic [OUT_W5-1:0] acc5;
  logic              v8, v5, o8, o5;
`ifdef ADC_ACCUMULATOR_DROP_COUNT_EN
  logic [15:0]       dc8, dc5;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  adc_accumulator #(.NCHANNELS(8), .DATA_W(DATA_W), .NACC_W(NACC_W), .TS_W(TS_W)) u_dut8 (
    .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .channel_i(channel),
    .data_ready_i(data_ready), .data_i(data), .number_of_samples_i(nos),
    .out_ready_i(out_ready), .accumulated_data_o(acc8), .data_valid_o(v8),
    .overrun_o(o8)
`ifdef ADC_ACCUMULATOR_DROP_COUNT_EN
    , .drop_count_o(dc8)
`endif
  );

  adc_accumulator #(.NCHANNELS(5), .DATA_W(DATA_W), .NACC_W(NACC_W), .TS_W(TS_W)) u_dut5 (
    .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .channel_i(channel),
    .data_ready_i(data_ready), .data_i(data), .number_of_samples_i(nos),
    .out_ready_i(out_ready), .accumulated_data_o(acc5), .data_valid_o(v5),
    .overrun_o(o5)
`ifdef ADC_ACCUMULATOR_DROP_COUNT_EN
    , .drop_count_o(dc5)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = 8-channel instance, 1 = 5-channel instance.
  longint unsigned m_sum  [2][8];
  int              m_cnt  [2][8];
  longint unsigned m_slot [2][8];
  int              m_nsamp[2];
  logic [TS_W-1:0] m_ts   [2];
  bit              m_valid[2];
  bit              m_ovr  [2];
  int              m_drop [2];
  logic [255:0]    exp_q0[$];
  logic [255:0]    exp_q1[$];

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic model_reset(input int k);
    for (int c = 0; c < 8; c++) begin
      m_sum[k][c]  = 0;
      m_cnt[k][c]  = 0;
      m_slot[k][c] = 0;
    end
    m_nsamp[k] = int'(nos);
    m_ts[k]    = '0;
    m_valid[k] = 0;
    m_ovr[k]   = 0;
    m_drop[k]  = 0;
    if (k == 0) exp_q0.delete();
    else        exp_q1.delete();
  endtask

  // One rising edge of the reference model, using the inputs currently driven.
  task automatic model_edge(input int k);
    int n;
    bit done;
    bit accepted;
    logic [255:0] fr;
    n = (k == 0) ? 8 : 5;
    done = 0;
    accepted = m_valid[k] && out_ready;
    if (!enable) begin
      for (int c = 0; c < 8; c++) m_cnt[k][c] = 0;
      m_nsamp[k] = int'(nos);
    end else if (data_ready && int'(channel) < n) begin
      int c;
      c = int'(channel);
      if (m_cnt[k][c] == 0) m_sum[k][c] = longint'(data);
      else                  m_sum[k][c] = m_sum[k][c] + longint'(data);
      m_cnt[k][c]++;
      if (m_cnt[k][c] == m_nsamp[k] + 1) begin
        m_slot[k][c] = m_sum[k][c];
        m_cnt[k][c]  = 0;
        done = (c == n - 1);
      end
    end
    if (done) begin
      fr = '0;
      for (int c = 0; c < n; c++) fr[(n-1-c)*ACC_W +: ACC_W] = ACC_W'(m_slot[k][c]);
      fr[n*ACC_W +: TS_W]          = m_ts[k];
      fr[n*ACC_W+TS_W +: NACC_W]   = NACC_W'(m_nsamp[k]);
      if (!m_valid[k] || out_ready) begin
        if (k == 0) exp_q0.push_back(fr);
        else        exp_q1.push_back(fr);
        m_valid[k] = 1;
      end else begin
        m_ovr[k] = 1;
        if (m_drop[k] < 65535) m_drop[k]++;
      end
      m_ts[k]    = m_ts[k] + 1'b1;
      m_nsamp[k] = int'(nos);
    end else if (accepted) begin
      m_valid[k] = 0;
    end
  endtask

  task automatic step(input bit en, input bit rdy, input bit str, input int ch, input int d);
    enable     = en;
    out_ready  = rdy;
    data_ready = str;
    channel    = ch[CH_W-1:0];
    data       = d[DATA_W-1:0];
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #2;
    check("rst_data8", acc8, '0);
    check("rst_data5", {72'b0, acc5}, '0);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic rounds(input int nr, input bit rdy, input int d);
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < 8; c++)
        step(1, rdy, 1, c, (d < 0) ? c + 1 : d);
  endtask

  // Monitor: status every cycle, frame contents on every handover.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        check("valid8", v8, m_valid[0]);
        check("valid5", v5, m_valid[1]);
        check("overrun8", o8, m_ovr[0]);
        check("overrun5", o5, m_ovr[1]);
`ifdef ADC_ACCUMULATOR_DROP_COUNT_EN
        check("drop8", dc8, m_drop[0]);
        check("drop5", dc5, m_drop[1]);
`endif
        if (v8 && out_ready) begin
          if (exp_q0.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL frame8: got %h expected none", acc8);
          end else check("frame8", acc8, exp_q0.pop_front());
        end
        if (v5 && out_ready) begin
          if (exp_q1.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL frame5: got %h expected none", acc5);
          end else check("frame5", {72'b0, acc5}, exp_q1.pop_front());
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; channel = '0; data_ready = 1'b0;
    data = '0; out_ready = 1'b1; nos = 12'd3;
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check("init_data8", acc8, '0);
    check("init_valid8", v8, 1'b0);

    // Basic frame: 4 samples per channel, data = channel+1.
    rounds(4, 1, -1);
    repeat (3) step(1, 1, 0, 0, 0);

    // Full-scale accumulation, maximum sample count.
    nos = 12'd4095;
    step(0, 1, 0, 0, 0);
    rounds(4096, 1, 4095);
    repeat (3) step(1, 1, 0, 0, 0);

    // Enable pulse mid-frame discards the partial run.
    nos = 12'd3;
    step(0, 1, 0, 0, 0);
    rounds(2, 1, -1);
    step(0, 1, 0, 0, 0);
    rounds(4, 1, 17);
    repeat (2) step(1, 1, 0, 0, 0);

    // Reset mid-frame; the next frame restarts timestamps at 0.
    rounds(2, 1, -1);
    do_reset();
    rounds(4, 1, -1);
    repeat (2) step(1, 1, 0, 0, 0);

    // Consumer stalls across two completions, then drains.
    nos = 12'd0;
    step(0, 1, 0, 0, 0);
    rounds(2, 0, -1);
    repeat (2) step(1, 0, 0, 0, 0);
    repeat (2) step(1, 1, 0, 0, 0);
    rounds(1, 1, 5);
    repeat (2) step(1, 1, 0, 0, 0);

    // Accept and new completion on the same edge.
    rounds(1, 0, 9);
    for (int c = 0; c < 7; c++) step(1, 0, 1, c, 3);
    step(1, 1, 1, 7, 3);
    repeat (2) step(1, 1, 0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) nos = NACC_W'($urandom_range(0, 3));
      if (i % 1000 == 999) do_reset();
      else step(($urandom % 50) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)));
    end

    repeat (4) step(1, 1, 0, 0, 0);
    check("drain8", 256'(exp_q0.size()), '0);
    check("drain5", 256'(exp_q1.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
